// File: rtl/case_word_encoder.sv
// Code-to-word encoder: maps a code in 1..256 to four 32-bit symbol beats on a valid/ready stream.
// Optional macro CASE_ENC_ERR_CNT_EN adds a saturating 8-bit illegal-code counter output (err_cnt).
module case_word_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  in_code,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        err
`ifdef CASE_ENC_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [7:0]  idx_q;
    logic        err_q;

    logic        accept;
    logic        legal;
    logic [7:0]  idx_d;
    logic [1:0]  sel;

    function automatic logic [31:0] sym(input logic [1:0] s);
        logic [31:0] v;
        unique case (s)
            2'd0:    v = 32'hDEADBEEF;
            2'd1:    v = 32'h0BAD0B01;
            2'd2:    v = 32'hC001D00D;
            default: v = 32'h12345678;
        endcase
        return v;
    endfunction

    // Code 256 wraps to low byte 0, so subtracting in 8 bits still yields idx 255.
    assign idx_d  = in_code[7:0] - 8'd1;
    assign legal  = (in_code != 9'd0) && (in_code <= 9'd256);
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            idx_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && !legal;
            unique case (state_q)
                IDLE: begin
                    if (accept && legal) begin
                        idx_q   <= idx_d;
                        cnt_q   <= 2'd0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        sel = 2'd0;
        unique case (cnt_q)
            2'd0:    sel = idx_q[7:6];
            2'd1:    sel = idx_q[5:4];
            2'd2:    sel = idx_q[3:2];
            default: sel = idx_q[1:0];
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? sym(sel) : 32'h0;
    assign out_last  = out_valid && (cnt_q == 2'd3);
    assign err       = err_q;

`ifdef CASE_ENC_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              err_cnt_q <= 8'd0;
        else if (err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_case_word_encoder.sv
// Self-checking bench for case_word_encoder: beat-queue model checked every cycle plus directed literal words.
module tb_case_word_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  in_code = 9'd0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, out_last, err;
    logic [31:0] out_data;
`ifdef CASE_ENC_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    case_word_encoder dut (
        .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .err(err)
`ifdef CASE_ENC_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    logic [31:0] SYM [4] = '{32'hDEADBEEF, 32'h0BAD0B01, 32'hC001D00D, 32'h12345678};

    int pass_cnt = 0, tot_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] model_word(input int code);
        int idx;
        logic [127:0] w;
        idx = code - 1;
        w = '0;
        for (int b = 0; b < 4; b++) w = (w << 32) | 128'(SYM[(idx / (1 << (6 - 2 * b))) % 4]);
        return w;
    endfunction

    // Model: queue of beats still owed by the DUT; empty queue means idle.
    logic [31:0]  exp_q[$];
    logic [127:0] words[$];
    logic [127:0] asm_w, cur_word;
    logic         err_pend = 1'b0;
    bit           idle;
    int           model_errs = 0;
    int           err_seen = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_err", err, 0);
            exp_q.delete();
            err_pend = 1'b0;
            asm_w = '0;
            model_errs = 0;
        end else begin
            idle = (exp_q.size() == 0);
            chk("in_ready", in_ready, idle);
            chk("out_valid", out_valid, !idle);
            chk("err", err, err_pend);
            if (idle) begin
                chk("out_data_idle", out_data, 0);
                chk("out_last_idle", out_last, 0);
            end else begin
                chk("out_data", out_data, exp_q[0]);
                chk("out_last", out_last, exp_q.size() == 1);
            end
`ifdef CASE_ENC_ERR_CNT_EN
            chk("err_cnt", err_cnt, model_errs);
`endif
            if (err) begin
                err_seen++;
                if (model_errs < 255) model_errs++;
            end
            err_pend = idle && in_valid && (in_code == 0 || in_code > 256);
            if (idle && in_valid && in_code != 0 && in_code <= 256) begin
                cur_word = model_word(int'(in_code));
                for (int b = 0; b < 4; b++) exp_q.push_back(cur_word[127 - 32 * b -: 32]);
                asm_w = '0;
            end else if (!idle && out_ready) begin
                asm_w = {asm_w[95:0], out_data};
                if (exp_q.size() == 1) begin
                    chk("word", asm_w, cur_word);
                    words.push_back(asm_w);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [8:0] c);
        int t = 0;
        in_code = c;
        in_valid = 1'b1;
        do begin @(negedge clk); t++; end while (!in_ready && t < 100);
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin @(negedge clk); t++; end while (!(exp_q.size() == 0 && in_ready) && t < 400);
        if (t >= 400) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_word(input string name, input logic [127:0] exp);
        if (words.size() == 0) chk(name, 128'hx, exp);
        else chk(name, words.pop_front(), exp);
    endtask

    bit done;
    int e0;

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Code 1: four A beats, first beat visible one cycle after acceptance
        send(9'd1);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 32'hDEADBEEF);
        wait_idle();
        chk_word("w1", {4{32'hDEADBEEF}});

        send(9'd142); wait_idle();
        chk_word("w142", {32'hC001D00D, 32'hDEADBEEF, 32'h12345678, 32'h0BAD0B01});
        send(9'd256); wait_idle();
        chk_word("w256", {4{32'h12345678}});

        // Illegal codes
        e0 = err_seen;
        send(9'd0);
        @(negedge clk);
        chk("err0_pulse", err, 1);
        @(posedge clk); #1;
        send(9'd300);
        repeat (3) @(negedge clk);
        chk("err_count_seen", err_seen - e0, 2);
        chk("err_no_valid", out_valid, 0);
`ifdef CASE_ENC_ERR_CNT_EN
        chk("err_cnt_2", err_cnt, 2);
`endif
        @(posedge clk); #1;

        // Backpressure on beat1; input traffic during SEND is ignored
        out_ready = 1'b0;
        send(9'd65);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_code = 9'd7;
        repeat (3) begin
            @(negedge clk);
            chk("hold_b1", out_data, 32'hDEADBEEF);
            chk("hold_last", out_last, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        wait_idle();
        chk_word("w65", {32'h0BAD0B01, {3{32'hDEADBEEF}}});

        // Reset during beat2 of 241
        send(9'd241);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_beat2", out_data, 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_last", out_last, 0);
        @(posedge clk); #1 rst = 1'b0;
`ifdef CASE_ENC_ERR_CNT_EN
        chk("err_cnt_rst", err_cnt, 0);
`endif
        send(9'd2); wait_idle();
        chk("no_partial_word", words.size(), 1);
        chk_word("w2", {{3{32'hDEADBEEF}}, 32'h0BAD0B01});

        // All 256 codes with random backpressure and gaps
        words.delete();
        done = 1'b0;
        fork
            begin
                for (int c = 1; c <= 256; c++) begin
                    send(9'(c));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                wait_idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1 out_ready = 1'($urandom % 2);
                end
            end
        join
        out_ready = 1'b1;
        chk("rand_word_count", words.size(), 256);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end
endmodule
